// File: rtl/stb_capture_sequencer_if.sv
// Buffer-side and host-side ready/valid channels of the capture sequencer.
// master = sequencer, slave = trace buffer plus host stream.
interface stb_capture_sequencer_if #(
  parameter int CTRL_W = 8,
  parameter int STAT_W = 8,
  parameter int DATA_W = 32
);
  logic              CONTROL_VALID_O;
  logic              CONTROL_READY_I;
  logic [CTRL_W-1:0] CONTROL_O;
  logic              STATUS_VALID_I;
  logic              STATUS_READY_O;
  logic [STAT_W-1:0] STATUS_I;
  logic              DATA_VALID_I;
  logic              DATA_READY_O;
  logic [DATA_W-1:0] DATA_I;
  logic              HOST_VALID_O;
  logic              HOST_READY_I;
  logic [DATA_W-1:0] HOST_DATA_O;
  logic              HOST_LAST_O;

  modport master (
    output CONTROL_VALID_O, CONTROL_O,
    input  CONTROL_READY_I,
    input  STATUS_VALID_I, STATUS_I,
    output STATUS_READY_O,
    input  DATA_VALID_I, DATA_I,
    output DATA_READY_O,
    output HOST_VALID_O, HOST_DATA_O, HOST_LAST_O,
    input  HOST_READY_I
  );

  modport slave (
    input  CONTROL_VALID_O, CONTROL_O,
    output CONTROL_READY_I,
    output STATUS_VALID_I, STATUS_I,
    input  STATUS_READY_O,
    output DATA_VALID_I, DATA_I,
    input  DATA_READY_O,
    input  HOST_VALID_O, HOST_DATA_O, HOST_LAST_O,
    output HOST_READY_I
  );
endinterface

// File: rtl/stb_capture_sequencer.sv
// Trace buffer capture sequencer: configure, wait for trigger,
// drain a fixed word count to the host stream.
module stb_capture_sequencer #(
  parameter int CTRL_W     = 8,
  parameter int STAT_W     = 8,
  parameter int DATA_W     = 32,
  parameter int READ_WORDS = 64,
  parameter int TRG_BIT    = 0,
  parameter int TIMEOUT    = 0
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              START_I,
  input  logic [CTRL_W-1:0] CONFIG_I,
  input  logic              ABORT_I,
  output logic              BUSY_O,
  output logic              DONE_O,
  output logic              ERROR_O,
  output logic [STAT_W-1:0] LAST_STATUS_O,
  stb_capture_sequencer_if.master bus
);

  localparam int WT = $clog2(READ_WORDS + 1);
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [WT-1:0] RW_CNT = WT'(READ_WORDS);
  localparam logic [WT-1:0] RW_LAST = WT'(READ_WORDS - 1);
  localparam logic [WW-1:0] TO_LAST =
    (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_WAIT_TRG,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t        state;
  logic [WT-1:0] words_taken;
  logic [WW-1:0] wait_cnt;

  logic ctrl_hs;
  logic stat_hs;
  logic data_hs;
  logic host_hs;
  logic trig;

  assign ctrl_hs = bus.CONTROL_VALID_O & bus.CONTROL_READY_I;
  assign stat_hs = bus.STATUS_VALID_I & bus.STATUS_READY_O;
  assign data_hs = bus.DATA_VALID_I & bus.DATA_READY_O;
  assign host_hs = bus.HOST_VALID_O & bus.HOST_READY_I;
  assign trig    = stat_hs & bus.STATUS_I[TRG_BIT];

  // Only unregistered output: lets a word move every cycle.
  assign bus.DATA_READY_O = (state == S_DRAIN)
    & (~bus.HOST_VALID_O | bus.HOST_READY_I)
    & (words_taken < RW_CNT);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state              <= S_IDLE;
      BUSY_O             <= 1'b0;
      DONE_O             <= 1'b0;
      ERROR_O            <= 1'b0;
      LAST_STATUS_O      <= '0;
      bus.CONTROL_VALID_O <= 1'b0;
      bus.CONTROL_O      <= '0;
      bus.STATUS_READY_O <= 1'b1;
      bus.HOST_VALID_O   <= 1'b0;
      bus.HOST_DATA_O    <= '0;
      bus.HOST_LAST_O    <= 1'b0;
      words_taken        <= '0;
      wait_cnt           <= '0;
    end else begin
      DONE_O             <= 1'b0;
      bus.STATUS_READY_O <= 1'b1;
      if (stat_hs)
        LAST_STATUS_O <= bus.STATUS_I;
      if (ABORT_I && state != S_IDLE) begin
        state               <= S_IDLE;
        BUSY_O              <= 1'b0;
        bus.CONTROL_VALID_O <= 1'b0;
        bus.HOST_VALID_O    <= 1'b0;
        bus.HOST_DATA_O     <= '0;
        bus.HOST_LAST_O     <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (START_I && !ABORT_I) begin
              state               <= S_CONFIG;
              BUSY_O              <= 1'b1;
              ERROR_O             <= 1'b0;
              bus.CONTROL_O       <= CONFIG_I;
              bus.CONTROL_VALID_O <= 1'b1;
              words_taken         <= '0;
              wait_cnt            <= '0;
            end
          end
          S_CONFIG: begin
            if (ctrl_hs) begin
              bus.CONTROL_VALID_O <= 1'b0;
              state               <= S_WAIT_TRG;
            end
          end
          S_WAIT_TRG: begin
            if (trig) begin
              state       <= S_DRAIN;
              words_taken <= '0;
            end else if (TIMEOUT > 0 && wait_cnt == TO_LAST) begin
              ERROR_O <= 1'b1;
              BUSY_O  <= 1'b0;
              state   <= S_IDLE;
            end else if (wait_cnt != TO_LAST) begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          S_DRAIN: begin
            // A new word and a last-word drain never coincide:
            // the last load already exhausts words_taken.
            if (data_hs) begin
              bus.HOST_VALID_O <= 1'b1;
              bus.HOST_DATA_O  <= bus.DATA_I;
              bus.HOST_LAST_O  <= (words_taken == RW_LAST);
              words_taken      <= words_taken + 1'b1;
            end else if (host_hs) begin
              bus.HOST_VALID_O <= 1'b0;
              if (bus.HOST_LAST_O) begin
                state  <= S_FINISH;
                DONE_O <= 1'b1;
              end
            end
          end
          S_FINISH: begin
            state  <= S_IDLE;
            BUSY_O <= 1'b0;
          end
          default: begin
            state  <= S_IDLE;
            BUSY_O <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
